mips_mc_ctrl: RTL and testbench

- Multi-cycle control FSM for the MIPS32 datapath.
- Decodes the opcode/funct of the latched instruction and sequences fetch, decode, execute, memory and writeback.
- Drives every datapath mux select (reg-dst 5-bit 3:1, ALU-B 32-bit 3:1, writeback 32-bit 3:1, PC-source 32-bit 3:1), the write enables and the memory request handshake.
- Sits beside the register file/ALU; one instance per core.

---
 rtl/mips_pkg.sv | 92 +++++++++
 rtl/mips_mc_ctrl_if.sv | 39 +++
 rtl/mips_instr_decode.sv | 53 +++++
 rtl/mips_mc_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 multi-cycle core: opcode/funct codes,
// ALU operation codes, datapath mux select encodings and controller states.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // ADD is code 0 so that an idle controller drives an all-zero alu_op.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_ADDU = 4'h1,
        ALU_SUB  = 4'h2,
        ALU_SUBU = 4'h3,
        ALU_AND  = 4'h4,
        ALU_OR   = 4'h5,
        ALU_XOR  = 4'h6,
        ALU_NOR  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9,
        ALU_LUI  = 4'hA
    } alu_op_e;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] ALUB_REG  = 2'b00;
    localparam logic [1:0] ALUB_FOUR = 2'b01;
    localparam logic [1:0] ALUB_IMM  = 2'b10;

    localparam logic [1:0] WB_ALU    = 2'b00;
    localparam logic [1:0] WB_MEM    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_ADDR,
        ST_MEM,
        ST_WBMEM,
        ST_BRANCH,
        ST_JUMP
    } state_e;

    typedef enum logic [3:0] {
        CLS_ILL,
        CLS_R,
        CLS_JR,
        CLS_IMM,
        CLS_LW,
        CLS_SW,
        CLS_BR,
        CLS_J,
        CLS_JAL
    } instr_class_e;

    // Logical immediates and lui take a zero-extended immediate.
    function automatic logic is_zero_ext_imm(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_LUI);
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Control/handshake bundle between the multi-cycle controller and the
// datapath/memory side of the core.
interface mips_mc_ctrl_if;

    logic                 run;
    logic [5:0]           opcode;
    logic [5:0]           funct;
    logic                 alu_zero;
    logic                 mem_ready;

    logic                 mem_req;
    logic                 mem_we;
    logic                 ir_write;
    logic                 pc_write;
    logic                 reg_write;
    logic [1:0]           reg_dst_sel;
    logic [1:0]           alu_b_sel;
    logic [1:0]           wb_sel;
    logic [1:0]           pc_src_sel;
    mips_pkg::alu_op_e    alu_op;
    logic                 illegal;
    logic                 busy;
    logic                 zero_ext;

    modport master (
        input  run, opcode, funct, alu_zero, mem_ready,
        output mem_req, mem_we, ir_write, pc_write, reg_write,
        output reg_dst_sel, alu_b_sel, wb_sel, pc_src_sel, alu_op,
        output illegal, busy, zero_ext
    );

    modport slave (
        output run, opcode, funct, alu_zero, mem_ready,
        input  mem_req, mem_we, ir_write, pc_write, reg_write,
        input  reg_dst_sel, alu_b_sel, wb_sel, pc_src_sel, alu_op,
        input  illegal, busy, zero_ext
    );

endinterface

// File: rtl/mips_instr_decode.sv
// Combinational classifier: maps opcode/funct of the latched instruction to
// an instruction class, the ALU operation and the immediate-extension mode.
module mips_instr_decode
    import mips_pkg::*;
(
    input  logic [5:0]    opcode_i,
    input  logic [5:0]    funct_i,
    output instr_class_e  cls_o,
    output alu_op_e       alu_op_o,
    output logic          zero_ext_o
);

    always_comb begin
        cls_o      = CLS_ILL;
        alu_op_o   = ALU_ADD;
        zero_ext_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD:  begin cls_o = CLS_R; alu_op_o = ALU_ADD;  end
                    FN_ADDU: begin cls_o = CLS_R; alu_op_o = ALU_ADDU; end
                    FN_SUB:  begin cls_o = CLS_R; alu_op_o = ALU_SUB;  end
                    FN_SUBU: begin cls_o = CLS_R; alu_op_o = ALU_SUBU; end
                    FN_AND:  begin cls_o = CLS_R; alu_op_o = ALU_AND;  end
                    FN_OR:   begin cls_o = CLS_R; alu_op_o = ALU_OR;   end
                    FN_XOR:  begin cls_o = CLS_R; alu_op_o = ALU_XOR;  end
                    FN_NOR:  begin cls_o = CLS_R; alu_op_o = ALU_NOR;  end
                    FN_SLT:  begin cls_o = CLS_R; alu_op_o = ALU_SLT;  end
                    FN_SLTU: begin cls_o = CLS_R; alu_op_o = ALU_SLTU; end
                    FN_JR:   cls_o = CLS_JR;
                    default: cls_o = CLS_ILL;
                endcase
            end
            OP_ADDI:  begin cls_o = CLS_IMM; alu_op_o = ALU_ADD;  end
            OP_ADDIU: begin cls_o = CLS_IMM; alu_op_o = ALU_ADDU; end
            OP_SLTI:  begin cls_o = CLS_IMM; alu_op_o = ALU_SLT;  end
            OP_ANDI:  begin cls_o = CLS_IMM; alu_op_o = ALU_AND;  end
            OP_ORI:   begin cls_o = CLS_IMM; alu_op_o = ALU_OR;   end
            OP_LUI:   begin cls_o = CLS_IMM; alu_op_o = ALU_LUI;  end
            OP_LW:    cls_o = CLS_LW;
            OP_SW:    cls_o = CLS_SW;
            OP_BEQ,
            OP_BNE:   cls_o = CLS_BR;
            OP_J:     cls_o = CLS_J;
            OP_JAL:   cls_o = CLS_JAL;
            default:  cls_o = CLS_ILL;
        endcase
        if (cls_o == CLS_IMM) begin
            zero_ext_o = is_zero_ext_imm(opcode_i);
        end
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS32 control FSM: sequences fetch/decode/execute/memory/
// writeback and drives all datapath selects, write enables and memory requests.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned RESET_WAIT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    mips_mc_ctrl_if.master  bus
);

    state_e        state_q, state_d;
    logic [3:0]    wait_q, wait_d;

    instr_class_e  cls_q;
    alu_op_e       alu_op_q;
    logic          zext_q;
    logic          bne_q;

    instr_class_e  dec_cls;
    alu_op_e       dec_alu_op;
    logic          dec_zext;

    mips_instr_decode u_decode (
        .opcode_i   (bus.opcode),
        .funct_i    (bus.funct),
        .cls_o      (dec_cls),
        .alu_op_o   (dec_alu_op),
        .zero_ext_o (dec_zext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wait_q  <= 4'(RESET_WAIT);
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Decode result is captured once per instruction so later states decode
    // from registers rather than the instruction bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_q    <= CLS_ILL;
            alu_op_q <= ALU_ADD;
            zext_q   <= 1'b0;
            bne_q    <= 1'b0;
        end else if (state_q == ST_DECODE) begin
            cls_q    <= dec_cls;
            alu_op_q <= dec_alu_op;
            zext_q   <= dec_zext;
            bne_q    <= bus.opcode[0];
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else if (bus.run) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (dec_cls)
                    CLS_R, CLS_IMM:         state_d = ST_EXEC;
                    CLS_LW, CLS_SW:         state_d = ST_ADDR;
                    CLS_BR:                 state_d = ST_BRANCH;
                    CLS_J, CLS_JAL, CLS_JR: state_d = ST_JUMP;
                    default:                state_d = ST_FETCH;
                endcase
            end
            ST_EXEC:   state_d = ST_WB;
            ST_WB:     state_d = ST_FETCH;
            ST_ADDR:   state_d = ST_MEM;
            ST_MEM: begin
                if (bus.mem_ready) begin
                    state_d = (cls_q == CLS_SW) ? ST_FETCH : ST_WBMEM;
                end
            end
            ST_WBMEM:  state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            ST_JUMP:   state_d = ST_FETCH;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.reg_write   = 1'b0;
        bus.reg_dst_sel = REGDST_RT;
        bus.alu_b_sel   = ALUB_REG;
        bus.wb_sel      = WB_ALU;
        bus.pc_src_sel  = PCSRC_SEQ;
        bus.alu_op      = ALU_ADD;
        bus.illegal     = 1'b0;
        bus.busy        = (state_q != ST_IDLE);
        bus.zero_ext    = zext_q;
        case (state_q)
            ST_FETCH: begin
                // IR/PC latch only on the completing cycle so a stalled fetch
                // writes them exactly once.
                bus.mem_req    = 1'b1;
                bus.alu_b_sel  = ALUB_FOUR;
                bus.pc_src_sel = PCSRC_SEQ;
                bus.ir_write   = bus.mem_ready;
                bus.pc_write   = bus.mem_ready;
            end
            ST_DECODE: begin
                bus.illegal = (dec_cls == CLS_ILL);
            end
            ST_EXEC: begin
                bus.alu_b_sel = (cls_q == CLS_IMM) ? ALUB_IMM : ALUB_REG;
                bus.alu_op    = alu_op_q;
            end
            ST_WB: begin
                bus.reg_write   = 1'b1;
                bus.wb_sel      = WB_ALU;
                bus.reg_dst_sel = (cls_q == CLS_R) ? REGDST_RD : REGDST_RT;
            end
            ST_ADDR: begin
                bus.alu_b_sel = ALUB_IMM;
                bus.alu_op    = ALU_ADD;
            end
            ST_MEM: begin
                // Address-phase selects held so the address stays stable under stall.
                bus.mem_req   = 1'b1;
                bus.mem_we    = (cls_q == CLS_SW);
                bus.alu_b_sel = ALUB_IMM;
                bus.alu_op    = ALU_ADD;
            end
            ST_WBMEM: begin
                bus.reg_write   = 1'b1;
                bus.wb_sel      = WB_MEM;
                bus.reg_dst_sel = REGDST_RT;
            end
            ST_BRANCH: begin
                bus.alu_op     = ALU_SUB;
                bus.alu_b_sel  = ALUB_REG;
                bus.pc_src_sel = PCSRC_BR;
                bus.pc_write   = bne_q ? ~bus.alu_zero : bus.alu_zero;
            end
            ST_JUMP: begin
                bus.pc_src_sel = PCSRC_JMP;
                bus.pc_write   = 1'b1;
                if (cls_q == CLS_JAL) begin
                    bus.reg_write   = 1'b1;
                    bus.reg_dst_sel = REGDST_RA;
                    bus.wb_sel      = WB_PC4;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: per-instruction expected cycle traces
// are built from the instruction-class rules and compared every cycle.
module tb_mips_mc_ctrl;
    import mips_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mips_mc_ctrl_if bus ();

    mips_mc_ctrl #(.RESET_WAIT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam int K_ILL = 0, K_R = 1, K_JR = 2, K_IMM = 3, K_LW = 4,
                   K_SW = 5, K_BR = 6, K_J = 7, K_JAL = 8;

    typedef struct {
        logic        rdy;
        logic [18:0] exp;
        logic [18:0] care;
    } step_t;

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: begin
                if (fn == 6'h08) return K_JR;
                if ((fn >= 6'h20 && fn <= 6'h27) || fn == 6'h2A || fn == 6'h2B) return K_R;
                return K_ILL;
            end
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F: return K_IMM;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h04, 6'h05: return K_BR;
            6'h02: return K_J;
            6'h03: return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] exp_alu(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            case (fn)
                6'h20: return ALU_ADD;
                6'h21: return ALU_ADDU;
                6'h22: return ALU_SUB;
                6'h23: return ALU_SUBU;
                6'h24: return ALU_AND;
                6'h25: return ALU_OR;
                6'h26: return ALU_XOR;
                6'h27: return ALU_NOR;
                6'h2A: return ALU_SLT;
                6'h2B: return ALU_SLTU;
                default: return ALU_ADD;
            endcase
        end
        case (op)
            6'h08: return ALU_ADD;
            6'h09: return ALU_ADDU;
            6'h0A: return ALU_SLT;
            6'h0C: return ALU_AND;
            6'h0D: return ALU_OR;
            6'h0F: return ALU_LUI;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // c = {we, reg_dst, alu_b, wb, pc_src, alu_op} care flags; enables and busy always checked.
    function automatic step_t mk(input logic rdy, input logic req, input logic we,
                                 input logic irw, input logic pcw, input logic rw,
                                 input logic ill, input logic [1:0] rd, input logic [1:0] ab,
                                 input logic [1:0] wb, input logic [1:0] ps,
                                 input logic [3:0] op, input logic [5:0] c);
        step_t s;
        s.rdy  = rdy;
        s.exp  = {req, we, irw, pcw, rw, ill, 1'b1, rd, ab, wb, ps, op};
        s.care = {1'b1, c[5], 5'b11111, {2{c[4]}}, {2{c[3]}}, {2{c[2]}}, {2{c[1]}}, {4{c[0]}}};
        return s;
    endfunction

    function automatic logic [18:0] outs();
        return {bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.reg_write,
                bus.illegal, bus.busy, bus.reg_dst_sel, bus.alu_b_sel, bus.wb_sel,
                bus.pc_src_sel, bus.alu_op};
    endfunction

    // Entered during a FETCH cycle; returns at the negedge of the next FETCH cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fstall,
                             input int mstall, input logic zero, input string tag,
                             input int abort_at);
        step_t q[$];
        int    k;
        logic  jal;
        k   = classify(op, fn);
        jal = (k == K_JAL);
        bus.opcode   = op;
        bus.funct    = fn;
        bus.alu_zero = zero;
        for (int i = 0; i < fstall; i++)
            q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, ALUB_FOUR, 2'd0, PCSRC_SEQ, 4'd0, 6'b101010));
        q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, ALUB_FOUR, 2'd0, PCSRC_SEQ, 4'd0, 6'b101010));
        q.push_back(mk(rb(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (k == K_ILL), 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 6'b000000));
        case (k)
            K_R, K_IMM: begin
                q.push_back(mk(rb(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0,
                               (k == K_R) ? ALUB_REG : ALUB_IMM, 2'd0, 2'd0, exp_alu(op, fn), 6'b001001));
                q.push_back(mk(rb(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                               (k == K_R) ? REGDST_RD : REGDST_RT, 2'd0, WB_ALU, 2'd0, 4'd0, 6'b010100));
            end
            K_LW, K_SW: begin
                q.push_back(mk(rb(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, ALUB_IMM, 2'd0, 2'd0, ALU_ADD, 6'b001001));
                for (int i = 0; i < mstall; i++)
                    q.push_back(mk(1'b0, 1'b1, (k == K_SW), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, ALUB_IMM, 2'd0, 2'd0, ALU_ADD, 6'b101001));
                q.push_back(mk(1'b1, 1'b1, (k == K_SW), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, ALUB_IMM, 2'd0, 2'd0, ALU_ADD, 6'b101001));
                if (k == K_LW)
                    q.push_back(mk(rb(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, REGDST_RT, 2'd0, WB_MEM, 2'd0, 4'd0, 6'b010100));
            end
            K_BR: begin
                q.push_back(mk(rb(), 1'b0, 1'b0, 1'b0, (op == 6'h04) ? zero : !zero, 1'b0, 1'b0,
                               2'd0, ALUB_REG, 2'd0, PCSRC_BR, ALU_SUB, 6'b001011));
            end
            K_J, K_JR, K_JAL: begin
                q.push_back(mk(rb(), 1'b0, 1'b0, 1'b0, 1'b1, jal, 1'b0, jal ? REGDST_RA : 2'd0, 2'd0,
                               jal ? WB_PC4 : 2'd0, PCSRC_JMP, 4'd0, jal ? 6'b010110 : 6'b000010));
            end
            default: ;
        endcase
        foreach (q[i]) begin
            bus.mem_ready = q[i].rdy;
            bus.run       = rb();
            #1;
            checks++;
            if ((outs() & q[i].care) !== (q[i].exp & q[i].care)) begin
                failures++;
                $display("FAIL %s step %0d op=%h fn=%h: got %h want %h (care %h)",
                         tag, i, op, fn, outs() & q[i].care, q[i].exp & q[i].care, q[i].care);
            end
            if (i == abort_at) begin
                #1;
                rst_n = 1'b0;
                #1;
                checks++;
                if ({outs(), bus.zero_ext} !== 20'd0) begin
                    failures++;
                    $display("FAIL %s async_reset_outputs: got %h want 0", tag, {outs(), bus.zero_ext});
                end
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_fetch(input string tag);
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.busy !== 1'b1 || bus.ir_write !== 1'b0 ||
            bus.illegal !== 1'b0 || bus.reg_write !== 1'b0 || bus.mem_we !== 1'b0) begin
            failures++;
            $display("FAIL %s fetch: got req=%b busy=%b irw=%b ill=%b rw=%b we=%b want 1 1 0 0 0 0",
                     tag, bus.mem_req, bus.busy, bus.ir_write, bus.illegal, bus.reg_write, bus.mem_we);
        end
        @(negedge clk);
    endtask

    // rst_n is low on entry; releases it with run=1 and expects FETCH on the 2nd edge.
    task automatic release_and_check(input string tag);
        @(negedge clk);
        bus.run       = 1'b1;
        bus.mem_ready = 1'b0;
        rst_n         = 1'b1;
        #1;
        checks++;
        if (outs() !== 19'd0) begin
            failures++;
            $display("FAIL %s idle_after_release: got %h want 0", tag, outs());
        end
        @(negedge clk);
        #1;
        checks++;
        if (outs() !== 19'd0) begin
            failures++;
            $display("FAIL %s idle_wait: got %h want 0", tag, outs());
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.mem_req !== 1'b1 || bus.ir_write !== 1'b0) begin
            failures++;
            $display("FAIL %s fetch_2nd_edge: got busy=%b req=%b irw=%b want 1 1 0",
                     tag, bus.busy, bus.mem_req, bus.ir_write);
        end
    endtask

    task automatic test_reset();
        bus.run = 1'b1; bus.mem_ready = 1'b0; bus.alu_zero = 1'b0;
        bus.opcode = 6'h00; bus.funct = 6'h20;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({outs(), bus.zero_ext} !== 20'd0) begin
            failures++;
            $display("FAIL reset_state: got %h want 0", {outs(), bus.zero_ext});
        end
        release_and_check("reset");
    endtask

    task automatic test_r_add();
        run_instr(6'h00, 6'h20, 0, 0, 1'b0, "r_add", -1);
        check_fetch("r_add_next");
        run_instr(6'h0D, 6'h00, 1, 0, 1'b0, "ori", -1);
        check_fetch("ori_next");
    endtask

    task automatic test_lw_stall();
        run_instr(6'h23, 6'h11, 1, 3, 1'b0, "lw_stall", -1);
        check_fetch("lw_next");
        run_instr(6'h2B, 6'h05, 0, 2, 1'b1, "sw_stall", -1);
        check_fetch("sw_next");
    endtask

    task automatic test_branch();
        run_instr(6'h04, 6'h00, 0, 0, 1'b1, "beq_taken", -1);
        run_instr(6'h04, 6'h00, 0, 0, 1'b0, "beq_not", -1);
        run_instr(6'h05, 6'h00, 0, 0, 1'b1, "bne_not", -1);
        run_instr(6'h05, 6'h00, 2, 0, 1'b0, "bne_taken", -1);
        check_fetch("branch_next");
    endtask

    task automatic test_jal();
        run_instr(6'h03, 6'h00, 0, 0, 1'b0, "jal", -1);
        run_instr(6'h02, 6'h00, 0, 0, 1'b0, "j", -1);
        run_instr(6'h00, 6'h08, 0, 0, 1'b0, "jr", -1);
        check_fetch("jump_next");
    endtask

    task automatic test_illegal();
        run_instr(6'h3F, 6'h00, 0, 0, 1'b0, "illegal_op", -1);
        check_fetch("illegal_next");
        run_instr(6'h00, 6'h3F, 0, 0, 1'b0, "illegal_fn", -1);
        check_fetch("illegal_fn_next");
    endtask

    task automatic test_mid_reset();
        run_instr(6'h23, 6'h00, 0, 6, 1'b0, "mid_reset", 4);
        release_and_check("mid_reset");
    endtask

    task automatic test_run_gate();
        @(negedge clk);
        #2;
        bus.run = 1'b0;
        rst_n   = 1'b0;
        #1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin
                failures++;
                $display("FAIL run_gate idle %0d: got busy=%b req=%b want 0 0", i, bus.busy, bus.mem_req);
            end
            @(negedge clk);
        end
        bus.run = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.mem_req !== 1'b1) begin
            failures++;
            $display("FAIL run_gate start: got busy=%b req=%b want 1 1", bus.busy, bus.mem_req);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 80; n++) begin
            int sel;
            int sel2;
            logic [5:0] op;
            logic [5:0] fn;
            sel  = int'($urandom_range(0, 15));
            sel2 = int'($urandom_range(0, 11));
            case (sel)
                0, 1, 2: op = 6'h00;
                3:  op = 6'h08;
                4:  op = 6'h09;
                5:  op = 6'h0A;
                6:  op = 6'h0C;
                7:  op = 6'h0D;
                8:  op = 6'h0F;
                9:  op = 6'h23;
                10: op = 6'h2B;
                11: op = 6'h04;
                12: op = 6'h05;
                13: op = 6'h02;
                14: op = 6'h03;
                default: op = 6'($urandom);
            endcase
            case (sel2)
                8:  fn = 6'h2A;
                9:  fn = 6'h2B;
                10: fn = 6'h08;
                11: fn = 6'($urandom);
                default: fn = 6'h20 + 6'(sel2);
            endcase
            run_instr(op, fn, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), rb(), "random", -1);
        end
        check_fetch("random_end");
    endtask

    initial begin
        test_reset();
        test_r_add();
        test_lw_stall();
        test_branch();
        test_jal();
        test_illegal();
        test_mid_reset();
        test_run_gate();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
